// File: rtl/wr_stream_packer_if.sv
// ---------------------------------------------------------------------------
// wr_stream_packer_if
//   Bundles the word-stream input handshake and the byte-wide FIFO write port
//   of wr_stream_packer.
//
//   Stream side : s_valid, s_data (MSB byte first), s_last, s_ready
//   FIFO side   : fifo_w_en, fifo_wdata, fifo_wfull
//
//   Modports
//     slave  - the packer (consumes the stream, drives the FIFO write port)
//     master - the environment (drives the stream, models the FIFO)
// ---------------------------------------------------------------------------
interface wr_stream_packer_if #(
  parameter int DWIDTH   = 8,
  parameter int IN_BYTES = 4
);
  logic                         s_valid;
  logic [IN_BYTES*DWIDTH-1:0]   s_data;
  logic                         s_last;
  logic                         s_ready;
  logic                         fifo_w_en;
  logic [DWIDTH-1:0]            fifo_wdata;
  logic                         fifo_wfull;

  modport slave (
    input  s_valid, s_data, s_last, fifo_wfull,
    output s_ready, fifo_w_en, fifo_wdata
  );

  modport master (
    output s_valid, s_data, s_last, fifo_wfull,
    input  s_ready, fifo_w_en, fifo_wdata
  );
endinterface

// File: rtl/wr_stream_packer.sv
// ---------------------------------------------------------------------------
// wr_stream_packer
//   Serialises IN_BYTES-wide words into a byte stream for an async FIFO write
//   port. Each frame is written as:
//     SOF_BYTE, payload bytes (MSB byte of each word first), XOR checksum.
//   Consecutive words of one frame are accepted without a bubble, so a busy
//   FIFO sees one byte per cycle.
//
//   Ports
//     wclk, wrst_n : write-domain clock, asynchronous active-low reset
//     bus          : stream input + FIFO write port (wr_stream_packer_if.slave)
//     busy         : high whenever the FSM is not IDLE
//     frame_cnt    : completed frames, wraps 0xFFFF -> 0x0000
// ---------------------------------------------------------------------------
module wr_stream_packer #(
  parameter int                DWIDTH   = 8,
  parameter int                IN_BYTES = 4,
  parameter logic [DWIDTH-1:0] SOF_BYTE = 8'hA5
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  wr_stream_packer_if.slave    bus,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam int                IDX_W    = $clog2(IN_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(IN_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WAIT,
    TRAILER
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   byte_idx;
  logic [DWIDTH-1:0]  hold_bytes [IN_BYTES];  // index 0 = most significant byte
  logic               hold_last;
  logic [DWIDTH-1:0]  csum;
  logic [DWIDTH-1:0]  cur_byte;
  logic               at_last;
  logic               accept;

  assign cur_byte = hold_bytes[byte_idx];
  assign at_last  = (byte_idx == LAST_IDX);
  assign accept   = bus.s_valid && bus.s_ready;
  assign busy     = (state != IDLE);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state <= IDLE;
    else         state <= state_nx;
  end

  // -------------------------------------------------------------------------
  // Next-state and outputs. A full FIFO blocks every transition that depends
  // on a write, so the presented byte stays put until it is taken.
  // -------------------------------------------------------------------------
  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nx       = state;
    bus.s_ready    = 1'b0;
    bus.fifo_w_en  = 1'b0;
    bus.fifo_wdata = '0;
    unique case (state)
      IDLE: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) state_nx = HDR;
      end
      HDR: begin
        bus.fifo_w_en  = !bus.fifo_wfull;
        bus.fifo_wdata = SOF_BYTE;
        if (!bus.fifo_wfull) state_nx = DATA;
      end
      DATA: begin
        bus.fifo_w_en  = !bus.fifo_wfull;
        bus.fifo_wdata = cur_byte;
        // Take the next word on the same cycle the final byte leaves, so a
        // multi-word frame streams without a gap.
        bus.s_ready    = at_last && !bus.fifo_wfull && !hold_last;
        if (!bus.fifo_wfull && at_last) begin
          if (hold_last)        state_nx = TRAILER;
          else if (bus.s_valid) state_nx = DATA;
          else                  state_nx = WAIT;
        end
      end
      WAIT: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) state_nx = DATA;
      end
      TRAILER: begin
        bus.fifo_w_en  = !bus.fifo_wfull;
        bus.fifo_wdata = csum;
        if (!bus.fifo_wfull) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: byte index, hold register, running checksum, frame counter.
  // A word load comes after the write handling so it wins on byte_idx when
  // the last byte and the next word coincide.
  // -------------------------------------------------------------------------
  // NOTE: the hold register is a handful of flops rather than a RAM, so it is
  // reset along with the rest of the state; do not do this for real memories.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      byte_idx  <= '0;
      hold_last <= 1'b0;
      csum      <= '0;
      frame_cnt <= '0;
      for (int i = 0; i < IN_BYTES; i++) hold_bytes[i] <= '0;
    end else begin
      if (bus.fifo_w_en) begin
        unique case (state)
          HDR:     byte_idx <= '0;
          DATA: begin
            csum <= csum ^ cur_byte;
            if (!at_last) byte_idx <= byte_idx + 1'b1;
          end
          TRAILER: frame_cnt <= frame_cnt + 1'b1;
          default: ;
        endcase
      end
      if (accept) begin
        for (int i = 0; i < IN_BYTES; i++)
          hold_bytes[i] <= bus.s_data[(IN_BYTES-1-i)*DWIDTH +: DWIDTH];
        hold_last <= bus.s_last;
        byte_idx  <= '0;
        if (state == IDLE) csum <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wr_stream_packer.sv
// ---------------------------------------------------------------------------
// tb_wr_stream_packer
//   Self-checking bench for wr_stream_packer (DWIDTH=8, IN_BYTES=4).
//   A reference model turns each accepted word into the bytes the frame must
//   contain (header, payload MSB first, XOR trailer) and queues them; a
//   monitor compares every FIFO write against that queue. Directed sequences
//   cover latency, back-to-back words, FIFO stalls, the WAIT gap, mid-frame
//   reset and frame counter wrap; randomized frames with a randomly full FIFO
//   follow.
// ---------------------------------------------------------------------------
module tb_wr_stream_packer;

  localparam int          DW  = 8;
  localparam int          NB  = 4;
  localparam logic [7:0]  SOF = 8'hA5;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        busy;
  logic [15:0] frame_cnt;

  wr_stream_packer_if #(.DWIDTH(DW), .IN_BYTES(NB)) bus ();

  wr_stream_packer #(
    .DWIDTH   (DW),
    .IN_BYTES (NB),
    .SOF_BYTE (SOF)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .bus       (bus),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 wclk = ~wclk;

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  int          wr_cycles [$];
  logic [7:0]  exp_q [$];
  bit          in_frame   = 1'b0;
  logic [7:0]  model_csum = '0;
  logic [15:0] exp_frames = '0;
  bit          rand_full  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  task automatic model_word(input logic [31:0] data, input logic last);
    logic [7:0] b;
    if (!in_frame) begin
      exp_q.push_back(SOF);
      model_csum = '0;
      in_frame   = 1'b1;
    end
    for (int i = 0; i < NB; i++) begin
      b = 8'((data >> (8 * (NB - 1 - i))) & 32'hFF);
      exp_q.push_back(b);
      model_csum = model_csum ^ b;
    end
    if (last) begin
      exp_q.push_back(model_csum);
      in_frame   = 1'b0;
      exp_frames = exp_frames + 16'd1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    in_frame   = 1'b0;
    exp_frames = '0;
  endtask

  // ---------------- monitor: samples 1 ns before each rising edge ----------------
  always begin
    @(negedge wclk);
    #4;
    if (wrst_n) begin
      if (bus.fifo_wfull) check("wen_while_full", bus.fifo_w_en, 0);
      if (bus.fifo_w_en) begin
        wr_cycles.push_back(cyc);
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("wdata", bus.fifo_wdata, exp_q.pop_front());
      end
    end
    cyc++;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge wclk);
    if (rand_full) bus.fifo_wfull = ($urandom_range(0, 3) == 0);
    #1;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    bit acc = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    bus.s_last  = last;
    for (int t = 0; t < 100 && !acc; t++) begin
      #1;
      acc = bus.s_ready;
      if (acc) acc_cyc = cyc;
      tick();
    end
    bus.s_valid = 1'b0;
    check("word_accepted", acc, 1);
    if (acc) model_word(data, last);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && (exp_q.size() != 0 || busy); t++) tick();
    check("drain_done", (exp_q.size() == 0) && !busy, 1);
    check("frame_cnt", frame_cnt, exp_frames);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    wrst_n          = 1'b0;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.s_last      = 1'b0;
    bus.fifo_wfull  = 1'b0;

    // Reset values
    #3;
    check("rst_s_ready",   bus.s_ready,   1);
    check("rst_fifo_w_en", bus.fifo_w_en, 0);
    check("rst_busy",      busy,          0);
    check("rst_frame_cnt", frame_cnt,     0);
    tick();
    tick();
    wrst_n = 1'b1;
    tick();

    // Single word: A5 11 22 33 44 44 on consecutive cycles, header at T+1
    wr_cycles.delete();
    send_word(32'h1122_3344, 1'b1);
    drain();
    check("single_nwr", wr_cycles.size(), 6);
    if (wr_cycles.size() == 6) begin
      check("single_hdr_latency", 32'(wr_cycles[0]), 32'(acc_cyc + 1));
      check("single_span", 32'(wr_cycles[5] - wr_cycles[0]), 5);
    end

    // Back-to-back words with no gap cycle
    wr_cycles.delete();
    send_word(32'h0102_0304, 1'b0);
    send_word(32'h0506_0708, 1'b1);
    drain();
    check("b2b_nwr", wr_cycles.size(), 10);
    if (wr_cycles.size() == 10)
      check("b2b_span", 32'(wr_cycles[9] - wr_cycles[0]), 9);

    // FIFO full for 3 cycles while 0x22 is presented
    send_word(32'h1122_3344, 1'b1);
    tick();
    tick();
    bus.fifo_wfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #2;
      check("stall_w_en",  bus.fifo_w_en,  0);
      check("stall_wdata", bus.fifo_wdata, 8'h22);
    end
    tick();
    bus.fifo_wfull = 1'b0;
    #1;
    check("resume_w_en",  bus.fifo_w_en,  1);
    check("resume_wdata", bus.fifo_wdata, 8'h22);
    drain();

    // Non-last word, s_valid low for a while, then the last word
    send_word(32'hA1B2_C3D4, 1'b0);
    repeat (6) tick();
    check("wait_busy",    busy,          1);
    check("wait_s_ready", bus.s_ready,   1);
    check("wait_w_en",    bus.fifo_w_en, 0);
    send_word(32'h0F1E_2D3C, 1'b1);
    drain();

    // Reset pulse after header + 2 payload bytes
    wr_cycles.delete();
    send_word(32'hDEAD_BEEF, 1'b0);
    tick();
    tick();
    tick();
    check("mid_rst_nwr", wr_cycles.size(), 3);
    wrst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_s_ready",   bus.s_ready,   1);
    check("mid_rst_w_en",      bus.fifo_w_en, 0);
    check("mid_rst_busy",      busy,          0);
    check("mid_rst_frame_cnt", frame_cnt,     0);
    tick();
    wrst_n = 1'b1;
    tick();
    send_word(32'h55AA_55AA, 1'b1);
    drain();

    // frame_cnt wrap
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    exp_frames = 16'hFFFF;
    tick();
    send_word(32'h0000_0001, 1'b1);
    drain();
    check("frame_cnt_wrap", frame_cnt, 16'h0000);

    // Randomized frames with a randomly full FIFO
    rand_full = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        send_word($urandom, w == nw - 1);
        repeat ($urandom_range(0, 2)) tick();
      end
      drain();
    end
    rand_full      = 1'b0;
    bus.fifo_wfull = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wr_stream_packer.md
WR_STREAM_PACKER -- requirements
Module: wr_stream_packer

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, meaning byte width of the FIFO write port.
REQ-002 The block SHALL have parameter IN_BYTES, default 4, meaning DWIDTH-bit bytes per input word (legal range >= 2).
REQ-003 The block SHALL have parameter SOF_BYTE, default 8'hA5, meaning the frame header byte value.
REQ-004 The block SHALL have port wclk, input, 1 bit: write-domain clock; all logic is rising-edge.
REQ-005 The block SHALL have port wrst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port s_valid, input, 1 bit: input word valid.
REQ-007 The block SHALL have port s_data, input, IN_BYTES*DWIDTH bits: input word, MSB byte first on the wire.
REQ-008 The block SHALL have port s_last, input, 1 bit: the word is the last word of its frame.
REQ-009 The block SHALL have port s_ready, output, 1 bit: a word is accepted when s_valid && s_ready at a wclk edge.
REQ-010 The block SHALL have port fifo_w_en, output, 1 bit: write strobe to the async FIFO write port.
REQ-011 The block SHALL have port fifo_wdata, output, DWIDTH bits: byte to the FIFO.
REQ-012 The block SHALL have port fifo_wfull, input, 1 bit: FIFO full flag, same domain, used combinationally.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever state != IDLE.
REQ-014 The block SHALL have port frame_cnt, output, 16 bits: count of completed frames, wraps 0xFFFF -> 0x0000.

Function
REQ-015 The FSM SHALL have states IDLE, HDR, DATA, WAIT, TRAILER; a byte counts as written only in a cycle where fifo_w_en=1.
REQ-016 fifo_w_en SHALL equal (state in {HDR, DATA, TRAILER}) && !fifo_wfull; it SHALL never assert while fifo_wfull=1.
REQ-017 In IDLE, s_ready=1; on acceptance, s_data/s_last SHALL be captured into a hold register, the checksum cleared, and the FSM SHALL go to HDR.
REQ-018 In HDR, fifo_wdata=SOF_BYTE; on write, FSM -> DATA with byte_idx=0.
REQ-019 In DATA, fifo_wdata SHALL be hold byte byte_idx (byte 0 = most significant); each write SHALL XOR that byte into the checksum.
REQ-020 In DATA, a write with byte_idx<IN_BYTES-1 SHALL increment byte_idx.
REQ-021 A DATA write with byte_idx=IN_BYTES-1 and hold_last=1 SHALL go to TRAILER.
REQ-022 In DATA, s_ready SHALL equal (byte_idx==IN_BYTES-1) && !fifo_wfull && !hold_last; on acceptance, the new word SHALL be loaded, byte_idx=0, FSM stays in DATA (no bubble).
REQ-023 A DATA write of the final byte with hold_last=0 and no accepted word SHALL go to WAIT.
REQ-024 In WAIT, s_ready=1 and fifo_w_en=0; on acceptance, FSM -> DATA with byte_idx=0 and no new header.
REQ-025 In TRAILER, fifo_wdata = the checksum (XOR of all payload bytes of the frame); on write, FSM -> IDLE and frame_cnt increments.
REQ-026 While fifo_wfull=1, state, byte_idx, hold register, checksum and fifo_wdata SHALL hold unchanged; output SHALL resume on the same byte.
REQ-027 s_ready SHALL be 0 in HDR and TRAILER; s_data SHALL be ignored when s_ready=0.
REQ-028 Latency: a word accepted at edge T SHALL produce the header write at cycle T+1 and the first payload byte at T+2 when the FIFO is not full; sustained throughput is 1 byte/cycle.
REQ-029 fifo_wdata is don't-care when fifo_w_en=0, except under REQ-026.

Reset
REQ-030 While wrst_n=0, state=IDLE, byte_idx=0, checksum=0, hold register=0, frame_cnt=0, busy=0, fifo_w_en=0, s_ready=1.
REQ-031 A reset asserted mid-frame SHALL abandon the frame immediately with no trailer written; after release, the next accepted word SHALL start a new frame with a header.

Verification
REQ-032 Single word 0x11223344, s_last=1, FIFO never full -> bytes A5,11,22,33,44,44 on consecutive cycles; frame_cnt 0->1.
REQ-033 Back-to-back words 0x01020304, 0x05060708 (last) with s_valid held high -> A5,01..08,08 written with no gap cycle.
REQ-034 fifo_wfull held high for 3 cycles while byte 0x22 is presented -> fifo_w_en=0 and fifo_wdata=0x22 stable for those cycles; 0x22 written on the first cycle after release.
REQ-035 Non-last word, then s_valid low for 5 cycles, then the last word -> FSM in WAIT with busy=1; no second A5; trailer correct.
REQ-036 wrst_n pulsed low after 2 payload bytes -> all outputs at reset values; the next frame starts with A5.
REQ-037 frame_cnt preset by driving 65535 frames (or forced) -> the next frame completion reads 0x0000.
